// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
//   MEM-stage load/store unit in front of a simple dual-port RAM with one
//   write port (A) and one synchronous read port (B). It handles byte, half
//   and word accesses. Loads are extracted little-endian and sign- or
//   zero-extended. Sub-word stores are done as read-modify-write. Misaligned
//   or reserved-size requests are rejected with misalign_err. At most one
//   request is in flight at a time.
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   req_valid       : request present; accepted when req_valid && ready
//   req_we          : 1 = store, 0 = load
//   req_size        : 00 byte, 01 half, 10 word, 11 reserved (error)
//   req_unsigned    : loads only, 1 = zero-extend, 0 = sign-extend
//   req_addr        : byte address
//   req_wdata       : store data, right-aligned
//   ready           : unit idle and not in reset
//   resp_valid      : one-cycle completion pulse
//   resp_rdata      : load result, held until the next load response
//   misalign_err    : qualifies resp_valid, request was rejected
//   ram_wea/addra/dina : RAM write port (word address)
//   ram_addrb       : RAM read port word address
//   ram_doutb       : RAM read data, valid one cycle after ram_addrb sampled
// ---------------------------------------------------------------------------
module mem_access_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        misalign_err,
    output logic        ram_wea,
    output logic [31:0] ram_addra,
    output logic [31:0] ram_dina,
    output logic [31:0] ram_addrb,
    input  logic [31:0] ram_doutb
);

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        LD_DONE,
        RMW_WAIT,
        RMW_MERGE,
        WR
    } state_t;

    state_t      state_q, state_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        misalign_q, misalign_d;
    logic        ram_wea_q, ram_wea_d;
    logic [31:0] ram_addra_q, ram_addra_d;
    logic [31:0] ram_dina_q, ram_dina_d;
    logic [31:0] ram_addrb_q, ram_addrb_d;

    // Request fields latched at accept; they are data only and need no reset.
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] wdata_q, wdata_d;

    logic        req_err;

    // Little-endian lane extraction followed by sign/zero extension.
    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [1:0]  size,
                                                 input logic        uns,
                                                 input logic [1:0]  off);
        logic [31:0] sh_b;
        logic [31:0] sh_h;
        logic [7:0]  b;
        logic [15:0] h;
        sh_b = word >> {off, 3'b000};
        sh_h = word >> {off[1], 4'b0000};
        b    = sh_b[7:0];
        h    = sh_h[15:0];
        case (size)
            2'b00:   load_extract = uns ? {24'b0, b} : {{24{b[7]}}, b};
            2'b01:   load_extract = uns ? {16'b0, h} : {{16{h[15]}}, h};
            default: load_extract = word;
        endcase
    endfunction

    // Replace the addressed lane(s) of the old word with the store data.
    function automatic logic [31:0] store_merge(input logic [31:0] word,
                                                input logic [31:0] wdata,
                                                input logic [1:0]  size,
                                                input logic [1:0]  off);
        logic [31:0] mask;
        logic [31:0] data;
        case (size)
            2'b00: begin
                mask = 32'h0000_00FF << {off, 3'b000};
                data = {24'b0, wdata[7:0]} << {off, 3'b000};
            end
            2'b01: begin
                mask = 32'h0000_FFFF << {off[1], 4'b0000};
                data = {16'b0, wdata[15:0]} << {off[1], 4'b0000};
            end
            default: begin
                mask = 32'hFFFF_FFFF;
                data = wdata;
            end
        endcase
        store_merge = (word & ~mask) | (data & mask);
    endfunction

    assign req_err = (req_size == 2'b11) ||
                     (req_size == 2'b01 && req_addr[0]) ||
                     (req_size == 2'b10 && (req_addr[1:0] != 2'b00));

    assign ready        = (state_q == IDLE) && !rst;
    assign resp_valid   = resp_valid_q;
    assign resp_rdata   = resp_rdata_q;
    assign misalign_err = misalign_q;
    assign ram_wea      = ram_wea_q;
    assign ram_addra    = ram_addra_q;
    assign ram_dina     = ram_dina_q;
    assign ram_addrb    = ram_addrb_q;

    always_comb begin
        state_d      = state_q;
        resp_valid_d = 1'b0;
        misalign_d   = 1'b0;
        ram_wea_d    = 1'b0;
        resp_rdata_d = resp_rdata_q;
        ram_addra_d  = ram_addra_q;
        ram_dina_d   = ram_dina_q;
        ram_addrb_d  = ram_addrb_q;
        size_d       = size_q;
        uns_d        = uns_q;
        off_d        = off_q;
        wdata_d      = wdata_q;

        case (state_q)
            IDLE: begin
                if (req_valid && ready) begin
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    off_d   = req_addr[1:0];
                    wdata_d = req_wdata;
                    if (req_err) begin
                        resp_valid_d = 1'b1;
                        misalign_d   = 1'b1;
                    end else if (!req_we) begin
                        ram_addrb_d = {2'b00, req_addr[31:2]};
                        state_d     = RD_WAIT;
                    end else if (req_size == 2'b10) begin
                        ram_wea_d   = 1'b1;
                        ram_addra_d = {2'b00, req_addr[31:2]};
                        ram_dina_d  = req_wdata;
                        state_d     = WR;
                    end else begin
                        // Sub-word store: fetch the old word first.
                        ram_addrb_d = {2'b00, req_addr[31:2]};
                        state_d     = RMW_WAIT;
                    end
                end
            end
            RD_WAIT:   state_d = LD_DONE;
            LD_DONE: begin
                resp_rdata_d = load_extract(ram_doutb, size_q, uns_q, off_q);
                resp_valid_d = 1'b1;
                state_d      = IDLE;
            end
            RMW_WAIT:  state_d = RMW_MERGE;
            RMW_MERGE: begin
                ram_dina_d  = store_merge(ram_doutb, wdata_q, size_q, off_q);
                ram_addra_d = ram_addrb_q;
                ram_wea_d   = 1'b1;
                state_d     = WR;
            end
            WR: begin
                // ram_wea drops via its default; the write lands on this edge.
                resp_valid_d = 1'b1;
                state_d      = IDLE;
            end
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
            misalign_q   <= 1'b0;
            resp_rdata_q <= 32'h0;
            ram_wea_q    <= 1'b0;
            ram_addra_q  <= 32'h0;
            ram_dina_q   <= 32'h0;
            ram_addrb_q  <= 32'h0;
        end else begin
            state_q      <= state_d;
            resp_valid_q <= resp_valid_d;
            misalign_q   <= misalign_d;
            resp_rdata_q <= resp_rdata_d;
            ram_wea_q    <= ram_wea_d;
            ram_addra_q  <= ram_addra_d;
            ram_dina_q   <= ram_dina_d;
            ram_addrb_q  <= ram_addrb_d;
        end
    end

    always_ff @(posedge clk) begin
        size_q  <= size_d;
        uns_q   <= uns_d;
        off_q   <= off_d;
        wdata_q <= wdata_d;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have no parameters; data width is fixed at 32 bits; RAM addresses are word indices (byte address >> 2).
REQ-002 clk  in  1  single clock; all state SHALL change on posedge clk only.
REQ-003 rst  in  1  synchronous, active-high reset, sampled on posedge clk.
REQ-004 req_valid  in  1  MEM-stage request present.
REQ-005 req_we  in  1  1 = store, 0 = load.
REQ-006 req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-007 req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend.
REQ-008 req_addr  in  32  byte address.
REQ-009 req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-010 ready  out  1  combinational, equal to (state==IDLE && !rst); a request is accepted on a posedge where req_valid && ready.
REQ-011 resp_valid  out  1  one-cycle completion pulse.
REQ-012 resp_rdata  out  32  load result, held until the next resp_valid.
REQ-013 misalign_err  out  1  qualifies resp_valid: request rejected.
REQ-014 ram_wea  out  1  RAM write-port enable.
REQ-015 ram_addra  out  32  RAM write-port word address.
REQ-016 ram_dina  out  32  RAM write-port data.
REQ-017 ram_addrb  out  32  RAM read-port word address.
REQ-018 ram_doutb  in  32  RAM read data, valid one clk after ram_addrb is sampled (synchronous read).

Function
REQ-019 All RAM-side outputs, resp_valid, resp_rdata and misalign_err SHALL be registered.
REQ-020 States SHALL be IDLE, RD_WAIT, LD_DONE, RMW_WAIT, RMW_MERGE and WR. Accept edge = T0.
REQ-021 Alignment: half requires addr[0]=0; word requires addr[1:0]=0; req_size=11 is always an error.
REQ-022 Error request at T0 -> resp_valid=1 and misalign_err=1 in the cycle after T0; state stays IDLE; no ram_wea, and ram_addrb is unchanged.
REQ-023 Load at T0: ram_addrb<=addr[31:2]; IDLE->RD_WAIT->LD_DONE. At the LD_DONE->IDLE edge (T2), resp_rdata<=extracted value and resp_valid<=1, giving a latency of 2 cycles.
REQ-024 Extraction is little-endian: byte = doutb[8*addr[1:0]+7 -: 8]; half = doutb[16*addr[1]+15 -: 16]; the result is extended per req_unsigned; word loads ignore req_unsigned.
REQ-025 Word store at T0: ram_wea<=1, ram_addra<=addr[31:2], ram_dina<=wdata; state WR. At T1: ram_wea<=0, resp_valid<=1, state IDLE (latency 1).
REQ-026 Sub-word store is read-modify-write. At T0: ram_addrb<=addr[31:2], state RMW_WAIT. RMW_WAIT->RMW_MERGE at T1. At T2: ram_dina<=doutb with the addressed lane(s) replaced by wdata, ram_wea<=1, ram_addra<=word, state WR. At T3: resp_valid<=1 (latency 3).
REQ-027 The block SHALL latch the request at T0; inputs SHALL be ignored while ready=0, with no queuing; at most one request is in flight.
REQ-028 A request accepted at the edge on which a WR state completes SHALL NOT occur (ready=0 in WR), so every RMW read observes all prior writes.
REQ-029 ram_wea SHALL be high for exactly one cycle per store and never for loads or error requests.
REQ-030 resp_rdata SHALL update only on load responses; store and error responses leave it unchanged.

Reset
REQ-031 On rst, the block SHALL set: state=IDLE, ram_wea=0, resp_valid=0, misalign_err=0, resp_rdata=0, ram_addra=0, ram_dina=0, ram_addrb=0.
REQ-032 rst mid-operation SHALL abort the in-flight request with no response. A write whose ram_wea was already high in the cycle rst is sampled still lands in the RAM; no later write occurs.
REQ-033 ready SHALL be 0 while rst=1 and 1 in the first cycle after rst deasserts.

Verification
REQ-034 sw addr 0x10, data 0xDEADBEEF -> cycle after T0: ram_wea=1, ram_addra=4, ram_dina=0xDEADBEEF; resp_valid=1 one cycle later with misalign_err=0.
REQ-035 After REQ-034, the following loads SHALL return: lw 0x10 -> 0xDEADBEEF at T0+2; lb 0x13 -> 0xFFFFFFDE; lbu 0x13 -> 0x000000DE; lh 0x12 -> 0xFFFFDEAD; lhu 0x10 -> 0x0000BEEF.
REQ-036 sb 0x11, wdata 0x00000012 -> single ram_wea pulse with ram_addra=4, ram_dina=0xDEAD12EF; resp_valid at T0+3; a following lw 0x10 returns 0xDEAD12EF.
REQ-037 lw 0x12, sh 0x11 and size=11 -> each gives resp_valid with misalign_err=1 one cycle after accept; no ram_wea pulse; ram_addrb is unchanged.
REQ-038 rst asserted for one cycle while in RMW_MERGE of sb 0x10 -> no ram_wea pulse, no resp_valid, ready=1 the cycle after rst, and lw 0x10 still returns the pre-store word.
REQ-039 req_valid held high continuously with a sequence of 4 alternating sw/lw requests -> exactly one accept per IDLE cycle, 4 resp_valid pulses, and each lw returns the data from the preceding sw.
